// File: rtl/rom_load_pkg.sv
// Shared definitions for the ROM download controller: region map, write-strobe
// bit indices and FSM state encoding.
package rom_load_pkg;

  localparam int unsigned NUM_REGIONS = 3;

  localparam int unsigned WE_CPU  = 0;
  localparam int unsigned WE_GFX  = 1;
  localparam int unsigned WE_PROM = 2;

  localparam logic [15:0] CPU_BASE  = 16'h0000;
  localparam logic [15:0] CPU_SIZE  = 16'h4000;
  localparam logic [15:0] GFX_BASE  = 16'h4000;
  localparam logic [15:0] GFX_SIZE  = 16'h1000;
  localparam logic [15:0] PROM_BASE = 16'h5000;
  localparam logic [15:0] PROM_SIZE = 16'h0020;

  localparam logic [16:0] COUNT_MAX = 17'h1FFFF;

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_LOAD,
    ST_HOLD,
    ST_RUN,
    ST_ERROR
  } state_e;

endpackage

// File: rtl/rom_region_decode.sv
// Combinational download-address decoder: one-hot region hit plus the
// region-local byte address. No hit means the address is outside every region.
module rom_region_decode
  import rom_load_pkg::*;
(
  input  logic [15:0]            addr_i,
  output logic [NUM_REGIONS-1:0] hit_o,
  output logic [13:0]            local_addr_o
);

  localparam logic [15:0] CPU_END  = CPU_BASE + CPU_SIZE;
  localparam logic [15:0] GFX_END  = GFX_BASE + GFX_SIZE;
  localparam logic [15:0] PROM_END = PROM_BASE + PROM_SIZE;

  // Regions are contiguous from address 0, so each test only needs its upper bound.
  always_comb begin
    hit_o        = '0;
    local_addr_o = '0;
    if (addr_i < CPU_END) begin
      hit_o[WE_CPU] = 1'b1;
      local_addr_o  = addr_i[13:0] - CPU_BASE[13:0];
    end else if (addr_i < GFX_END) begin
      hit_o[WE_GFX] = 1'b1;
      local_addr_o  = addr_i[13:0] - GFX_BASE[13:0];
    end else if (addr_i < PROM_END) begin
      hit_o[WE_PROM] = 1'b1;
      local_addr_o   = addr_i[13:0] - PROM_BASE[13:0];
    end
  end

endmodule

// File: rtl/rom_load_ctrl.sv
// ROM download sequencer: routes download bytes to CPU/GFX/PROM regions and
// holds the core in reset until a valid load. ROM_CHECKSUM_EN adds a checksum check.
//
//   state    | meaning
//   ST_WAIT  | after reset, no load seen yet; core held in reset
//   ST_LOAD  | download window open; bytes decoded and written
//   ST_HOLD  | valid load or reset request; core_reset held for the hold count
//   ST_RUN   | core released
//   ST_ERROR | last load was short, out of range or bad checksum
module rom_load_ctrl
  import rom_load_pkg::*;
#(
  parameter int unsigned EXPECTED_BYTES = 20512,
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter logic [7:0]  EXPECTED_SUM   = 8'h00
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [15:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        core_rst_req,
  output logic        core_reset,
  output logic [2:0]  rom_we,
  output logic [13:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        load_err,
  output logic [16:0] byte_count,
  output logic [7:0]  chk_sum
);

  localparam int unsigned   HW        = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES);
  localparam logic [16:0]   EXP_COUNT = 17'(EXPECTED_BYTES);

  state_e                 state_q, state_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic                   dl_q;
  logic [16:0]            byte_count_q, byte_count_d;
  logic                   oor_q, oor_d;
  logic                   load_err_q, load_err_d;
  logic [NUM_REGIONS-1:0] rom_we_q, rom_we_d;
  logic [13:0]            rom_addr_q, rom_addr_d;
  logic [7:0]             rom_data_q, rom_data_d;

  logic [NUM_REGIONS-1:0] hit;
  logic [13:0]            local_addr;
  logic                   dl_rise, dl_fall;
  logic                   wr_in_load, wr_acc, wr_oor;
  logic                   sum_bad, load_bad;

  rom_region_decode u_decode (
    .addr_i       (ioctl_addr),
    .hit_o        (hit),
    .local_addr_o (local_addr)
  );

  assign dl_rise    = ioctl_download & ~dl_q;
  assign dl_fall    = ~ioctl_download & dl_q;
  assign wr_in_load = (state_q == ST_LOAD) & ioctl_wr & ~dl_rise;
  assign wr_acc     = wr_in_load & (|hit);
  assign wr_oor     = wr_in_load & ~(|hit);

  // Error decision uses the _d values so a write on the closing edge is included.
  assign load_bad = (byte_count_d < EXP_COUNT) | oor_d | sum_bad;

`ifdef ROM_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (dl_rise) begin
      sum_d = '0;
    end else if (wr_acc) begin
      sum_d = sum_q + ioctl_dout;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_bad = (sum_d != EXPECTED_SUM);
  assign chk_sum = sum_q;
`else
  // Masking keeps EXPECTED_SUM referenced so both builds share one parameter list.
  localparam logic [7:0] SUM_ZERO = EXPECTED_SUM & 8'h00;

  assign sum_bad = 1'b0;
  assign chk_sum = SUM_ZERO;
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_WAIT;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (dl_rise) begin
      state_d = ST_LOAD;
      hold_d  = '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (dl_fall) begin
            if (load_bad) begin
              state_d = ST_ERROR;
            end else begin
              state_d = ST_HOLD;
              hold_d  = HOLD_INIT;
            end
          end
        end
        ST_HOLD: begin
          if (core_rst_req) begin
            hold_d = HOLD_INIT;
          end else if (hold_q == '0) begin
            state_d = ST_RUN;
          end else begin
            hold_d = hold_q - 1'b1;
          end
        end
        ST_RUN: begin
          if (core_rst_req) begin
            state_d = ST_HOLD;
            hold_d  = HOLD_INIT;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    byte_count_d = byte_count_q;
    oor_d        = oor_q;
    load_err_d   = load_err_q;
    rom_we_d     = '0;
    rom_addr_d   = rom_addr_q;
    rom_data_d   = rom_data_q;
    if (dl_rise) begin
      byte_count_d = '0;
      oor_d        = 1'b0;
      load_err_d   = 1'b0;
    end else if (wr_acc) begin
      if (byte_count_q != COUNT_MAX) begin
        byte_count_d = byte_count_q + 17'd1;
      end
      rom_we_d   = hit;
      rom_addr_d = local_addr;
      rom_data_d = ioctl_dout;
    end else if (wr_oor) begin
      oor_d = 1'b1;
    end
    if ((state_q == ST_LOAD) && dl_fall && load_bad) begin
      load_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dl_q         <= 1'b0;
      byte_count_q <= '0;
      oor_q        <= 1'b0;
      load_err_q   <= 1'b0;
      rom_we_q     <= '0;
      rom_addr_q   <= '0;
      rom_data_q   <= '0;
    end else begin
      dl_q         <= ioctl_download;
      byte_count_q <= byte_count_d;
      oor_q        <= oor_d;
      load_err_q   <= load_err_d;
      rom_we_q     <= rom_we_d;
      rom_addr_q   <= rom_addr_d;
      rom_data_q   <= rom_data_d;
    end
  end

  always_comb begin
    core_reset = (state_q != ST_RUN);
    rom_we     = rom_we_q;
    rom_addr   = rom_addr_q;
    rom_data   = rom_data_q;
    load_err   = load_err_q;
    byte_count = byte_count_q;
  end

endmodule
